// File: rtl/param_data_memory.sv
// rtl/param_data_memory.sv - byte-addressable big-endian data memory with valid/ready access and fault response
module param_data_memory #(
  parameter int unsigned BASE_ADDR      = 1024,
  parameter int          DEPTH_BYTES    = 256,
  parameter int          WAIT_STATES    = 0,
  parameter bit          CLEAR_ON_RESET = 1'b1,
  localparam int         AW             = $clog2(DEPTH_BYTES),
  localparam int         IW             = (AW > 2) ? AW - 2 : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [1:0]    req_size,
  input  logic          req_signed,
  input  logic [31:0]   req_addr,
  input  logic [31:0]   req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_fault,
  input  logic [IW-1:0] dbg_idx,
  output logic [31:0]   dbg_word
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  logic [7:0]  mem [DEPTH_BYTES];

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic        cap_write;
  logic [1:0]  cap_size;
  logic        cap_signed;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;

  // In IDLE the live request drives the datapath so a zero-wait access commits on the accept edge.
  logic        a_write;
  logic [1:0]  a_size;
  logic        a_signed;
  logic [31:0] a_addr;
  logic [31:0] a_wdata;

  logic [32:0] off33;
  logic [33:0] off_end;
  logic [2:0]  nbytes;
  logic        fault;
  logic        accept;
  logic        commit;
  logic [AW-1:0] i0, i1, i2, i3;
  logic [7:0]  b0, b1, b2, b3;
  logic [31:0] load_val;
  logic [3:0]  wr_en;
  logic [AW-1:0] wr_idx [4];
  logic [7:0]  wr_byte [4];

  assign req_ready = (state == S_IDLE) && rst_n;
  assign rsp_valid = (state == S_RESP);
  assign accept    = req_valid && req_ready;

  always_comb begin
    a_write  = cap_write;
    a_size   = cap_size;
    a_signed = cap_signed;
    a_addr   = cap_addr;
    a_wdata  = cap_wdata;
    if (state == S_IDLE) begin
      a_write  = req_write;
      a_size   = req_size;
      a_signed = req_signed;
      a_addr   = req_addr;
      a_wdata  = req_wdata;
    end
  end

  always_comb begin
    nbytes = 3'd4;
    case (a_size)
      SZ_BYTE: nbytes = 3'd1;
      SZ_HALF: nbytes = 3'd2;
      default: nbytes = 3'd4;
    endcase
  end

  // Offset kept at 33 bits so addresses below the window or near the top of the space never wrap into range.
  assign off33   = {1'b0, a_addr} - 33'(BASE_ADDR);
  assign off_end = {1'b0, off33} + 34'(nbytes);

  always_comb begin
    fault = 1'b0;
    if (a_addr < BASE_ADDR)                           fault = 1'b1;
    if (off_end > 34'(DEPTH_BYTES))                   fault = 1'b1;
    if (a_size == SZ_HALF && a_addr[0])               fault = 1'b1;
    if (a_size == SZ_WORD && a_addr[1:0] != 2'b00)    fault = 1'b1;
    if (a_size == 2'b11)                              fault = 1'b1;
  end

  assign commit = rst_n && (
      ((state == S_IDLE) && accept && !fault && (WAIT_STATES == 0)) ||
      ((state == S_WAIT) && (cnt == 4'd0)));

  assign i0 = off33[AW-1:0];
  assign i1 = i0 + AW'(1);
  assign i2 = i0 + AW'(2);
  assign i3 = i0 + AW'(3);
  assign b0 = mem[i0];
  assign b1 = mem[i1];
  assign b2 = mem[i2];
  assign b3 = mem[i3];

  always_comb begin
    load_val = {b0, b1, b2, b3};
    case (a_size)
      SZ_BYTE: load_val = {{24{b0[7] & a_signed}}, b0};
      SZ_HALF: load_val = {{16{b0[7] & a_signed}}, b0, b1};
      default: load_val = {b0, b1, b2, b3};
    endcase
  end

  always_comb begin
    wr_en      = 4'b0000;
    wr_idx[0]  = i0;
    wr_idx[1]  = i1;
    wr_idx[2]  = i2;
    wr_idx[3]  = i3;
    wr_byte[0] = a_wdata[31:24];
    wr_byte[1] = a_wdata[23:16];
    wr_byte[2] = a_wdata[15:8];
    wr_byte[3] = a_wdata[7:0];
    if (commit && a_write) begin
      case (a_size)
        SZ_BYTE: begin
          wr_en      = 4'b0001;
          wr_byte[0] = a_wdata[7:0];
        end
        SZ_HALF: begin
          wr_en      = 4'b0011;
          wr_byte[0] = a_wdata[15:8];
          wr_byte[1] = a_wdata[7:0];
        end
        default: wr_en = 4'b1111;
      endcase
    end
  end

  generate
    if (CLEAR_ON_RESET) begin : g_mem_clear
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH_BYTES; i++) mem[i] <= '0;
        end else begin
          for (int k = 0; k < 4; k++) if (wr_en[k]) mem[wr_idx[k]] <= wr_byte[k];
        end
      end
    end else begin : g_mem_keep
      always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) if (wr_en[k]) mem[wr_idx[k]] <= wr_byte[k];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= 4'd0;
      rsp_rdata  <= 32'd0;
      rsp_fault  <= 1'b0;
      cap_write  <= 1'b0;
      cap_size   <= 2'b00;
      cap_signed <= 1'b0;
      cap_addr   <= 32'd0;
      cap_wdata  <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            cap_write  <= req_write;
            cap_size   <= req_size;
            cap_signed <= req_signed;
            cap_addr   <= req_addr;
            cap_wdata  <= req_wdata;
            if (fault) begin
              rsp_rdata <= 32'd0;
              rsp_fault <= 1'b1;
              state     <= S_RESP;
            end else if (WAIT_STATES == 0) begin
              rsp_rdata <= a_write ? 32'd0 : load_val;
              rsp_fault <= 1'b0;
              state     <= S_RESP;
            end else begin
              cnt   <= 4'(WAIT_STATES - 1);
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (cnt == 4'd0) begin
            rsp_rdata <= a_write ? 32'd0 : load_val;
            rsp_fault <= 1'b0;
            state     <= S_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign dbg_word = {mem[{dbg_idx, 2'd0}], mem[{dbg_idx, 2'd1}],
                     mem[{dbg_idx, 2'd2}], mem[{dbg_idx, 2'd3}]};

endmodule

// File: tb/tb_param_data_memory.sv
// tb/tb_param_data_memory.sv - scoreboard bench for param_data_memory (zero-wait/clearing and 3-wait/retaining instances)
module tb_param_data_memory;

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
  } exp_t;

  logic        clk;
  logic        rst_n      [2];
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_write  [2];
  logic [1:0]  req_size   [2];
  logic        req_signed [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic        rsp_valid  [2];
  logic        rsp_ready  [2];
  logic [31:0] rsp_rdata  [2];
  logic        rsp_fault  [2];
  logic [5:0]  dbg_idx    [2];
  logic [31:0] dbg_word   [2];

  exp_t q0[$];
  exp_t q1[$];
  int checks = 0;
  int fails  = 0;

  param_data_memory #(.BASE_ADDR(1024), .DEPTH_BYTES(256), .WAIT_STATES(0), .CLEAR_ON_RESET(1'b1)) u_dut0 (
    .clk(clk), .rst_n(rst_n[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_write(req_write[0]), .req_size(req_size[0]), .req_signed(req_signed[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]),
    .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]), .rsp_fault(rsp_fault[0]),
    .dbg_idx(dbg_idx[0]), .dbg_word(dbg_word[0]));

  param_data_memory #(.BASE_ADDR(1024), .DEPTH_BYTES(256), .WAIT_STATES(3), .CLEAR_ON_RESET(1'b0)) u_dut1 (
    .clk(clk), .rst_n(rst_n[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_write(req_write[1]), .req_size(req_size[1]), .req_signed(req_signed[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]),
    .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]), .rsp_fault(rsp_fault[1]),
    .dbg_idx(dbg_idx[1]), .dbg_word(dbg_word[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every response handshake.
  initial begin
    exp_t e;
    bit   got;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (rsp_valid[i] === 1'b1 && rsp_ready[i] === 1'b1) begin
          got = 1'b0;
          if (i == 0 && q0.size() > 0) begin e = q0.pop_front(); got = 1'b1; end
          if (i == 1 && q1.size() > 0) begin e = q1.pop_front(); got = 1'b1; end
          if (!got) begin
            checks++;
            fails++;
            $display("FAIL unexpected_rsp inst%0d: got rdata 0x%08h fault %0b, expected no response", i, rsp_rdata[i], rsp_fault[i]);
          end else begin
            chk($sformatf("rsp_rdata inst%0d", i), rsp_rdata[i], e.rdata);
            chk($sformatf("rsp_fault inst%0d", i), 32'(rsp_fault[i]), 32'(e.fault));
          end
        end
      end
    end
  end

  task automatic push_exp(input int i, input logic [31:0] rd, input logic f);
    exp_t e;
    e.rdata = rd;
    e.fault = f;
    if (i == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // Called just after a rising edge; returns just after the accept edge.
  task automatic issue(input int i, input logic wr, input logic [1:0] sz, input logic sg,
                       input logic [31:0] addr, input logic [31:0] wd);
    int n;
    req_write[i]  = wr;
    req_size[i]   = sz;
    req_signed[i] = sg;
    req_addr[i]   = addr;
    req_wdata[i]  = wd;
    req_valid[i]  = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (req_ready[i] === 1'b1) break;
      n++;
      if (n > 50) begin
        chk("accept_timeout", 32'(n), 32'd0);
        break;
      end
    end
    @(posedge clk);
    #1 req_valid[i] = 1'b0;
  endtask

  task automatic wait_rsp(input int i, input int lat_exp);
    int lat;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (rsp_valid[i] !== 1'b1 && lat < 40);
    chk($sformatf("latency inst%0d", i), 32'(lat), 32'(lat_exp));
    chk($sformatf("req_ready_in_resp inst%0d", i), 32'(req_ready[i]), 32'd0);
  endtask

  task automatic txn(input int i, input logic wr, input logic [1:0] sz, input logic sg,
                     input logic [31:0] addr, input logic [31:0] wd,
                     input logic [31:0] exp_rd, input logic exp_f, input int lat_exp);
    push_exp(i, exp_rd, exp_f);
    issue(i, wr, sz, sg, addr, wd);
    wait_rsp(i, lat_exp);
    @(posedge clk);
    @(negedge clk);
    chk($sformatf("rsp_valid_drop inst%0d", i), 32'(rsp_valid[i]), 32'd0);
    chk($sformatf("req_ready_after inst%0d", i), 32'(req_ready[i]), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_dbg(input int i, input logic [5:0] idx, input logic [31:0] exp);
    dbg_idx[i] = idx;
    #1;
    chk($sformatf("dbg_word inst%0d idx%0d", i, idx), dbg_word[i], exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] held;
    for (int i = 0; i < 2; i++) begin
      rst_n[i] = 1'b0; req_valid[i] = 1'b0; req_write[i] = 1'b0; req_size[i] = 2'b00;
      req_signed[i] = 1'b0; req_addr[i] = 32'd0; req_wdata[i] = 32'd0;
      rsp_ready[i] = 1'b1; dbg_idx[i] = 6'd0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset req_ready", 32'(req_ready[0]), 32'd0);
    chk("reset rsp_valid", 32'(rsp_valid[0]), 32'd0);
    chk("reset rsp_rdata", rsp_rdata[0], 32'd0);
    chk("reset rsp_fault", 32'(rsp_fault[0]), 32'd0);
    chk("reset cleared mem", dbg_word[0], 32'd0);
    @(posedge clk);
    #1 rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    @(negedge clk);
    chk("req_ready after release", 32'(req_ready[0]), 32'd1);
    @(posedge clk);
    #1;

    // Zero-wait instance: stores, extended loads, big-endian layout.
    txn(0, 1'b1, 2'b10, 1'b0, 32'd1024, 32'hDEADBEEF, 32'h0, 1'b0, 1);
    chk_dbg(0, 6'd0, 32'hDEADBEEF);
    txn(0, 1'b0, 2'b10, 1'b0, 32'd1024, 32'h0, 32'hDEADBEEF, 1'b0, 1);
    txn(0, 1'b0, 2'b00, 1'b1, 32'd1025, 32'h0, 32'hFFFFFFAD, 1'b0, 1);
    txn(0, 1'b0, 2'b00, 1'b0, 32'd1025, 32'h0, 32'h000000AD, 1'b0, 1);
    txn(0, 1'b0, 2'b01, 1'b1, 32'd1026, 32'h0, 32'hFFFFBEEF, 1'b0, 1);
    txn(0, 1'b0, 2'b01, 1'b0, 32'd1024, 32'h0, 32'h0000DEAD, 1'b0, 1);
    txn(0, 1'b1, 2'b00, 1'b0, 32'd1027, 32'h00000012, 32'h0, 1'b0, 1);
    txn(0, 1'b1, 2'b01, 1'b0, 32'd1024, 32'h0000A5A5, 32'h0, 1'b0, 1);
    chk_dbg(0, 6'd0, 32'hA5A5BE12);
    txn(0, 1'b1, 2'b10, 1'b0, 32'd1276, 32'hCAFEF00D, 32'h0, 1'b0, 1);
    chk_dbg(0, 6'd63, 32'hCAFEF00D);

    // Faults: no memory change, zero data.
    txn(0, 1'b0, 2'b10, 1'b0, 32'd1026, 32'h0, 32'h0, 1'b1, 1);
    txn(0, 1'b1, 2'b01, 1'b0, 32'd1025, 32'h0000FFFF, 32'h0, 1'b1, 1);
    txn(0, 1'b1, 2'b10, 1'b0, 32'd1280, 32'h11111111, 32'h0, 1'b1, 1);
    txn(0, 1'b0, 2'b00, 1'b1, 32'd1023, 32'h0, 32'h0, 1'b1, 1);
    txn(0, 1'b1, 2'b11, 1'b0, 32'd1024, 32'h77777777, 32'h0, 1'b1, 1);
    txn(0, 1'b0, 2'b10, 1'b0, 32'hFFFFFFFC, 32'h0, 32'h0, 1'b1, 1);
    chk_dbg(0, 6'd0, 32'hA5A5BE12);
    chk_dbg(0, 6'd63, 32'hCAFEF00D);
    txn(0, 1'b0, 2'b10, 1'b0, 32'd1276, 32'h0, 32'hCAFEF00D, 1'b0, 1);

    // Three-wait instance: latency, stall stability.
    txn(1, 1'b1, 2'b10, 1'b0, 32'd1028, 32'h11223344, 32'h0, 1'b0, 4);
    chk_dbg(1, 6'd1, 32'h11223344);
    rsp_ready[1] = 1'b0;
    push_exp(1, 32'h11223344, 1'b0);
    issue(1, 1'b0, 2'b10, 1'b0, 32'd1028, 32'h0);
    wait_rsp(1, 4);
    held = rsp_rdata[1];
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("stall rsp_valid", 32'(rsp_valid[1]), 32'd1);
      chk("stall rsp_rdata", rsp_rdata[1], held);
      chk("stall req_ready", 32'(req_ready[1]), 32'd0);
    end
    @(posedge clk);
    #1 rsp_ready[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("post-handshake rsp_valid", 32'(rsp_valid[1]), 32'd0);
    chk("post-handshake req_ready", 32'(req_ready[1]), 32'd1);
    @(posedge clk);
    #1;

    // Reset mid-WAIT drops the pending store; contents retained.
    issue(1, 1'b1, 2'b00, 1'b0, 32'd1030, 32'h00000055);
    @(posedge clk);
    #1 rst_n[1] = 1'b0;
    #1;
    chk("midreset rsp_valid", 32'(rsp_valid[1]), 32'd0);
    chk("midreset req_ready", 32'(req_ready[1]), 32'd0);
    chk("midreset rsp_rdata", rsp_rdata[1], 32'd0);
    chk("midreset rsp_fault", 32'(rsp_fault[1]), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n[1] = 1'b1;
    @(negedge clk);
    chk("req_ready after midreset", 32'(req_ready[1]), 32'd1);
    chk("rsp_valid after midreset", 32'(rsp_valid[1]), 32'd0);
    chk_dbg(1, 6'd1, 32'h11223344);
    @(posedge clk);
    #1;
    txn(1, 1'b0, 2'b00, 1'b0, 32'd1030, 32'h0, 32'h00000033, 1'b0, 4);
    chk("no dropped response", 32'(q1.size()), 32'd0);
    chk("scoreboard drained", 32'(q0.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
